hb_gen: RTL and testbench
=========================

Name: hb_gen

Overview:
- Heartbeat generator on each processor string; drives the 3-bit heartbeat bus consumed by the fault-detection unit's watchdog inputs (fdu0/fdu1).
- Advances a Gray-coded heartbeat only while string software keeps kicking it.
- Freezes the heartbeat when kicks stop, so the watchdog declares the string unhealthy.
- Honours the open-drain power-on-reset request returned by the fault-detection unit, holding the string processor in reset and rebooting it.

Parameters:
- HB_PERIOD, 2500000: clk cycles per heartbeat step (100 ms at 40 ns).
- KICK_TIMEOUT, 25000000: clk cycles without a kick before STALL (1 s).
- POR_MIN, 250: consecutive low cycles on synchronized por_n to accept a reset request (10 us).
- BOOT_HOLD, 12500000: cycles cpu_rst_n is held low after por_n releases (0.5 s).

Ports:
- clk, input, 1: system clock, 25 MHz.
- reset, input, 1: asynchronous, active-low reset.
- kick, input, 1: software-alive strobe; asynchronous to clk; rising edge counts.
- por_n, input, 1: reset request from the fault-detection unit; externally pulled up; low means reset.
- fault_stop, input, 1: test-only freeze of heartbeat advance; level, synchronous to clk.
- hb, output, 3: Gray-coded heartbeat to the fault-detection unit.
- cpu_rst_n, output, 1: active-low reset to the string processor.
- state_out, output, 2: current FSM state for LEDs.
- miss_count, output, 8: count of kick timeouts; saturates at 255.

Behaviour:
- Reset (reset=0), asynchronous, all outputs:
  - state = BOOT, hb = 3'b000, cpu_rst_n = 0, miss_count = 0, state_out = 2'b00.
  - All counters and synchronizer flops cleared.
- Input conditioning:
  - kick: 2-flop synchronizer, then rising-edge detect. kick_evt is a 1-cycle pulse, 3 cycles after the kick edge.
  - por_n: 2-flop synchronizer, reset value 1. por_cnt increments while the synced value is 0, clears to 0 when it is 1. por_req = (por_cnt >= POR_MIN - 1) and synced value is 0.
  - A por_n low shorter than POR_MIN cycles is ignored.
- Heartbeat sequence: 000, 001, 011, 010, 110, 111, 101, 100, then wraps to 000. Exactly one bit changes per step.
- States (encoding = state_out):
  - BOOT (00):
    - cpu_rst_n = 0; hb held at 000; boot_cnt counts up.
    - At boot_cnt == BOOT_HOLD-1: go to RUN, clear kick_cnt and per_cnt.
    - kick_evt ignored.
  - RUN (01):
    - cpu_rst_n = 1.
    - per_cnt counts up. At per_cnt == HB_PERIOD-1: hb takes the next Gray value and per_cnt returns to 0.
    - While fault_stop=1: per_cnt and hb hold. kick_cnt still runs.
    - kick_cnt clears on kick_evt, otherwise increments.
    - At kick_cnt == KICK_TIMEOUT-1 with no kick_evt that cycle: go to STALL; miss_count increments unless already 255.
    - A kick_evt in the same cycle as the timeout wins: stay in RUN, kick_cnt cleared.
  - STALL (10):
    - hb frozen at its last value; cpu_rst_n = 1.
    - kick_evt is ignored. STALL exits only through RESET.
  - RESET (11):
    - cpu_rst_n = 0; hb forced to 000.
    - Stays in RESET while synced por_n = 0.
    - First cycle with synced por_n = 1: go to BOOT, boot_cnt cleared.
- por_req has priority from any state, including BOOT and RESET: next state is RESET, boot_cnt cleared.
- hb, cpu_rst_n and state_out are registered. Each updates in the same cycle as the corresponding state or counter change.
- Counter widths: each is ceil(log2(parameter)) bits, minimum 1. Comparisons use equality with the terminal value, so counters never wrap.

Decomposition:
- Shared package hb_pkg:
  - State encodings BOOT/RUN/STALL/RESET.
  - Gray next-value function / 8-entry constant table.
  - Heartbeat width = 3.
- One sub-module, sync_edge: 2-flop synchronizer with a parameterized reset value, providing a level output and a rising-edge pulse output.
  - Instantiated once for kick and once for por_n.

Test Plan (bench parameters: HB_PERIOD=4, KICK_TIMEOUT=20, POR_MIN=3, BOOT_HOLD=10):
- Release reset, kick every 10 cycles:
  - cpu_rst_n rises and state_out = 01 after 10 cycles.
  - hb then steps 000→001→011→010→… every 4 cycles, wrapping 100→000 after 32 cycles.
- Stop kicking after entering RUN: 20 cycles after the last kick_evt, state_out = 10, hb frozen at its current value, miss_count = 1. Later kicks keep state_out = 10.
- Pulse por_n low for 2 cycles: no state change. Pulse it low for 5 cycles:
  - state_out = 11, hb = 000, cpu_rst_n = 0.
  - On release: BOOT for 10 cycles, then RUN.
- Time a kick so kick_evt coincides with kick_cnt == 19: remains in RUN, miss_count unchanged.
- fault_stop=1 for 12 cycles in RUN with kicks continuing: hb does not change and state stays 01. On release, hb resumes from the held value after the remaining per_cnt cycles.
- Force 256 timeouts (alternate STALL with a POR recovery each time): miss_count reads 255 and holds. Asserting reset mid-RUN returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared definitions for the heartbeat generator: state encodings, widths and the Gray step helper.
`timescale 1ns/1ps
package hb_pkg;

  localparam int unsigned HB_W   = 3;
  localparam int unsigned MISS_W = 8;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_RESET = 2'b11
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    if (n < 32'd2) return 32'd1;
    return 32'($clog2(n));
  endfunction

  // Next heartbeat value; exactly one bit flips per step.
  function automatic logic [HB_W-1:0] gray_next(input logic [HB_W-1:0] g);
    logic [HB_W-1:0] nxt;
    case (g)
      3'b000:  nxt = 3'b001;
      3'b001:  nxt = 3'b011;
      3'b011:  nxt = 3'b010;
      3'b010:  nxt = 3'b110;
      3'b110:  nxt = 3'b111;
      3'b111:  nxt = 3'b101;
      3'b101:  nxt = 3'b100;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hb_gen_sync_edge.sv
// Two-flop synchronizer with a configurable reset level, plus a rising-edge pulse.
`timescale 1ns/1ps
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level  = sync_q;
  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/hb_gen.sv
// Heartbeat generator: advances a Gray heartbeat while software kicks, freezes on kick loss,
// and holds the string processor in reset while the fault-detection unit requests it.
`timescale 1ns/1ps
module hb_gen
  import hb_pkg::*;
#(
  parameter int unsigned HB_PERIOD    = 2500000,
  parameter int unsigned KICK_TIMEOUT = 25000000,
  parameter int unsigned POR_MIN      = 250,
  parameter int unsigned BOOT_HOLD    = 12500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kick,
  input  logic              por_n,
  input  logic              fault_stop,
  output logic [HB_W-1:0]   hb,
  output logic              cpu_rst_n,
  output logic [1:0]        state_out,
  output logic [MISS_W-1:0] miss_count
);

  localparam int unsigned PER_W  = cnt_w(HB_PERIOD);
  localparam int unsigned KICK_W = cnt_w(KICK_TIMEOUT);
  localparam int unsigned POR_W  = cnt_w(POR_MIN);
  localparam int unsigned BOOT_W = cnt_w(BOOT_HOLD);

  localparam logic [PER_W-1:0]  PER_TERM  = PER_W'(HB_PERIOD - 1);
  localparam logic [KICK_W-1:0] KICK_TERM = KICK_W'(KICK_TIMEOUT - 1);
  localparam logic [POR_W-1:0]  POR_TERM  = POR_W'(POR_MIN - 1);
  localparam logic [BOOT_W-1:0] BOOT_TERM = BOOT_W'(BOOT_HOLD - 1);
  localparam logic [MISS_W-1:0] MISS_MAX  = '1;

  state_t              state_q, state_d;
  logic [BOOT_W-1:0]   boot_q, boot_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [KICK_W-1:0]   kick_q, kick_d;
  logic [POR_W-1:0]    por_q, por_d;
  logic [HB_W-1:0]     hb_q, hb_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                rst_n_q, rst_n_d;

  logic kick_lvl, kick_evt_c;
  logic por_lvl, por_rise_c;
  logic por_req_c;
  logic sync_unused_c;

  sync_edge #(.RST_VAL(1'b0)) u_kick_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (kick),
    .level  (kick_lvl),
    .rise_c (kick_evt_c)
  );

  sync_edge #(.RST_VAL(1'b1)) u_por_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (por_n),
    .level  (por_lvl),
    .rise_c (por_rise_c)
  );

  assign sync_unused_c = &{1'b0, kick_lvl, por_rise_c};

  // A reset request needs POR_MIN consecutive synchronized-low cycles.
  assign por_req_c = ~por_lvl & (por_q >= POR_TERM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      boot_q  <= '0;
      per_q   <= '0;
      kick_q  <= '0;
      por_q   <= '0;
      hb_q    <= '0;
      miss_q  <= '0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      per_q   <= per_d;
      kick_q  <= kick_d;
      por_q   <= por_d;
      hb_q    <= hb_d;
      miss_q  <= miss_d;
      rst_n_q <= rst_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    per_d   = per_q;
    kick_d  = kick_q;
    por_d   = por_q;
    hb_d    = hb_q;
    miss_d  = miss_q;
    rst_n_d = 1'b0;

    // Saturating low-run counter so it never wraps during long requests.
    if (por_lvl) begin
      por_d = '0;
    end else if (por_q != POR_TERM) begin
      por_d = por_q + POR_W'(1);
    end

    unique case (state_q)
      ST_BOOT: begin
        hb_d = '0;
        if (boot_q == BOOT_TERM) begin
          state_d = ST_RUN;
          kick_d  = '0;
          per_d   = '0;
        end else begin
          boot_d = boot_q + BOOT_W'(1);
        end
      end
      ST_RUN: begin
        if (!fault_stop) begin
          if (per_q == PER_TERM) begin
            per_d = '0;
            hb_d  = gray_next(hb_q);
          end else begin
            per_d = per_q + PER_W'(1);
          end
        end
        // A kick landing on the terminal cycle wins over the timeout.
        if (kick_evt_c) begin
          kick_d = '0;
        end else if (kick_q == KICK_TERM) begin
          state_d = ST_STALL;
          if (miss_q != MISS_MAX) miss_d = miss_q + MISS_W'(1);
        end else begin
          kick_d = kick_q + KICK_W'(1);
        end
      end
      ST_STALL: begin
      end
      ST_RESET: begin
        hb_d = '0;
        if (por_lvl) begin
          state_d = ST_BOOT;
          boot_d  = '0;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (por_req_c) begin
      state_d = ST_RESET;
      boot_d  = '0;
      hb_d    = '0;
    end

    rst_n_d = (state_d == ST_RUN) || (state_d == ST_STALL);
  end

  assign hb         = hb_q;
  assign cpu_rst_n  = rst_n_q;
  assign state_out  = state_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_hb_gen.sv
// Randomized bench for hb_gen against a cycle-level behavioural reference model.
`timescale 1ns/1ps
module tb_hb_gen;

  localparam int HBP = 4;
  localparam int KT  = 20;
  localparam int PM  = 3;
  localparam int BH  = 10;

  localparam int S_BOOT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_STALL = 2;
  localparam int S_RESET = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       kick = 1'b0;
  logic       por_n = 1'b1;
  logic       fault_stop = 1'b0;
  logic [2:0] hb;
  logic       cpu_rst_n;
  logic [1:0] state_out;
  logic [7:0] miss_count;

  int errors = 0;
  int checks = 0;

  hb_gen #(
    .HB_PERIOD   (HBP),
    .KICK_TIMEOUT(KT),
    .POR_MIN     (PM),
    .BOOT_HOLD   (BH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .kick       (kick),
    .por_n      (por_n),
    .fault_stop (fault_stop),
    .hb         (hb),
    .cpu_rst_n  (cpu_rst_n),
    .state_out  (state_out),
    .miss_count (miss_count)
  );

  always #20 clk = ~clk;

  // Reference model: heartbeat tracked as a step index into the Gray sequence.
  int GRAY [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int m_state, m_boot, m_per, m_kick, m_step, m_miss, m_low;
  bit k1, k2, k3, p1, p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_BOOT; m_boot = 0; m_per = 0; m_kick = 0;
    m_step = 0; m_miss = 0; m_low = 0;
    k1 = 0; k2 = 0; k3 = 0; p1 = 1; p2 = 1;
  endtask

  task automatic model_edge();
    bit evt, ps, req;
    int nstate;
    if (!reset) begin
      model_reset();
      return;
    end
    evt = k2 && !k3;
    ps  = p2;
    req = !ps && (m_low >= PM - 1);
    m_low = ps ? 0 : m_low + 1;
    nstate = m_state;
    case (m_state)
      S_BOOT: begin
        if (m_boot == BH - 1) begin nstate = S_RUN; m_kick = 0; m_per = 0; end
        else m_boot++;
      end
      S_RUN: begin
        if (!fault_stop) begin
          if (m_per == HBP - 1) begin m_per = 0; m_step = (m_step + 1) % 8; end
          else m_per++;
        end
        if (evt) m_kick = 0;
        else if (m_kick == KT - 1) begin
          nstate = S_STALL;
          if (m_miss < 255) m_miss++;
        end else m_kick++;
      end
      S_RESET: if (ps) begin nstate = S_BOOT; m_boot = 0; end
      default: ;
    endcase
    if (req) begin nstate = S_RESET; m_boot = 0; end
    if (nstate == S_BOOT || nstate == S_RESET) m_step = 0;
    m_state = nstate;
    k3 = k2; k2 = k1; k1 = kick;
    p2 = p1; p1 = por_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("hb", hb, GRAY[m_step]);
    check("state", state_out, m_state);
    check("cpu_rst_n", cpu_rst_n, (m_state == S_RUN || m_state == S_STALL) ? 1 : 0);
    check("miss", miss_count, m_miss);
  endtask

  task automatic run_kick(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      kick = (period > 0) && (i % period == 0);
      step();
    end
    kick = 1'b0;
  endtask

  task automatic run_por_low(input int n);
    por_n = 1'b0;
    for (int i = 0; i < n; i++) step();
    por_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_hb;
    int n;
    int kick_rate;
    int por_left;
    model_reset();

    // Reset values while reset is held low
    step();
    step();
    check("rst_hb", hb, 0);
    check("rst_state", state_out, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_miss", miss_count, 0);
    reset = 1'b1;

    // Boot then steady kicking; heartbeat walks and wraps
    run_kick(60, 10);
    check("run_reached", state_out, 2'b01);
    check("run_cpu_rst_n", cpu_rst_n, 1);

    // Kick loss leads to STALL; later kicks are ignored
    run_kick(30, 0);
    check("stall_state", state_out, 2'b10);
    check("stall_miss", miss_count, 1);
    run_kick(30, 5);
    check("stall_sticky", state_out, 2'b10);

    // Short POR pulse ignored, long pulse accepted
    run_por_low(2);
    run_kick(6, 0);
    check("short_por", state_out, 2'b10);
    por_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("por_state", state_out, 2'b11);
    por_n = 1'b1;
    step();
    check("por_hold_state", state_out, 2'b11);
    check("por_hb", hb, 0);
    check("por_cpu_rst_n", cpu_rst_n, 0);
    run_kick(25, 5);
    check("reboot_run", state_out, 2'b01);

    // Kick event landing on the terminal timeout cycle
    kick = 1'b1; step(); kick = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n = 0;
    while (m_kick != KT - 3 && n < 40) begin step(); n++; end
    if (m_kick != KT - 3) check("coinc_wait_kick_cnt", m_kick, KT - 3);
    kick = 1'b1; step(); kick = 1'b0;
    step();
    step();
    check("coinc_state", state_out, 2'b01);
    check("coinc_miss", miss_count, 1);
    run_kick(8, 0);
    check("coinc_still_run", state_out, 2'b01);

    // fault_stop freezes the heartbeat while kicks keep RUN alive
    run_kick(5, 4);
    fault_stop = 1'b1;
    step();
    exp_hb = GRAY[m_step];
    for (int i = 0; i < 12; i++) begin
      kick = (i % 6 == 0);
      step();
    end
    kick = 1'b0;
    check("fs_hold_hb", hb, exp_hb);
    check("fs_state", state_out, 2'b01);
    fault_stop = 1'b0;
    run_kick(10, 5);

    // Randomized traffic
    kick_rate = 4;
    por_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) kick_rate = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 8));
      kick = (kick_rate != 0) && ($urandom_range(0, kick_rate - 1) == 0);
      if ($urandom_range(0, 19) == 0) fault_stop = ~fault_stop;
      if (por_left > 0) begin
        por_n = 1'b0;
        por_left--;
      end else begin
        por_n = 1'b1;
        if ($urandom_range(0, 79) == 0) por_left = int'($urandom_range(1, 6));
      end
      step();
    end
    kick = 1'b0;
    fault_stop = 1'b0;
    por_n = 1'b1;

    // Repeated timeouts with POR recovery saturate the miss counter
    for (int it = 0; it < 258; it++) begin
      run_por_low(5);
      run_kick(40, 0);
    end
    check("miss_sat", miss_count, 255);
    check("miss_sat_stall", state_out, 2'b10);
    run_por_low(5);
    run_kick(30, 5);
    check("sat_run", state_out, 2'b01);
    check("sat_hold", miss_count, 255);

    // Asynchronous reset in the middle of RUN
    #5;
    reset = 1'b0;
    #1;
    check("async_hb", hb, 0);
    check("async_state", state_out, 0);
    check("async_cpu_rst_n", cpu_rst_n, 0);
    check("async_miss", miss_count, 0);
    model_reset();
    step();
    reset = 1'b1;
    run_kick(15, 0);
    check("post_reset_run", state_out, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
